// File: rtl/fm_sb_pkg.sv
// Shared types and helpers for the FM spy-buffer blocks.
package fm_sb_pkg;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StCapture = 2'd1,
      StPost    = 2'd2,
      StFrozen  = 2'd3
   } fm_sb_cap_state_t;

   localparam logic [1:0] PB_MODE_SPY      = 2'd0;
   localparam logic [1:0] PB_MODE_PLAYBACK = 2'd1;

   // Smallest legal spy-memory word width that holds a tapped payload.
   function automatic int unsigned sb_round_width(input int unsigned tp_dw);
      if (tp_dw <= 32) return 32;
      else if (tp_dw <= 64) return 64;
      else if (tp_dw <= 128) return 128;
      else return 256;
   endfunction

endpackage

// File: rtl/fm_sb_capture.sv
// Spy-buffer write front end: pads the monitor tap and writes it circularly
// into the spy memory with arm / trigger / post-trigger freeze control.
module fm_sb_capture
   import fm_sb_pkg::*;
#(
   parameter int unsigned TP_DW  = 51,
   parameter int unsigned SB_DW  = sb_round_width(TP_DW),
   parameter int unsigned MON_DW = 256,
   parameter int unsigned ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [MON_DW-1:0] fm_data,
   input  logic              fm_vld,
   input  logic [1:0]        pb_mode,
   input  logic              arm,
   input  logic              trig,
   input  logic [ADDR_W-1:0] post_trig,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [SB_DW-1:0]  mem_din,
   output logic              frozen,
   output logic              wrapped,
   output logic [ADDR_W-1:0] trig_addr,
   output logic [1:0]        state_o
);

   if (TP_DW > SB_DW || !(SB_DW == 32 || SB_DW == 64 || SB_DW == 128 || SB_DW == 256))
   begin : g_bad_width
      $fatal(1, "fm_sb_capture: illegal TP_DW/SB_DW combination");
   end

   fm_sb_cap_state_t  state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, cnt_q, trig_addr_q, mem_addr_q;
   logic [SB_DW-1:0]  mem_din_q;
   logic              mem_we_q, wrapped_q;
   logic              spy, restart, active, wr, trig_hit;
   logic              unused_tap;

   assign unused_tap = ^fm_data[MON_DW-1:TP_DW];

   assign spy      = (pb_mode == PB_MODE_SPY);
   assign restart  = spy && arm;
   // The arm cycle itself never writes; capture starts on the following cycle.
   assign active   = spy && !arm && (state_q == StCapture || state_q == StPost);
   assign wr       = active && fm_vld;
   assign trig_hit = active && (state_q == StCapture) && trig;

   always_ff @(posedge clk) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   // The trigger-cycle write counts toward post_trig, so post_trig=1 with a
   // valid word freezes straight away, like post_trig=0.
   always_comb begin
      state_d = state_q;
      if (!spy) begin
         state_d = StIdle;
      end else if (arm) begin
         state_d = StCapture;
      end else begin
         unique case (state_q)
            StCapture: begin
               if (trig) begin
                  if (post_trig == '0 || (fm_vld && post_trig == ADDR_W'(1))) state_d = StFrozen;
                  else state_d = StPost;
               end
            end
            StPost: if (fm_vld && cnt_q == ADDR_W'(1)) state_d = StFrozen;
            default: state_d = state_q;
         endcase
      end
   end

   always_comb begin
      frozen  = (state_q == StFrozen);
      state_o = state_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q       <= '0;
         cnt_q       <= '0;
         wrapped_q   <= 1'b0;
         trig_addr_q <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_din_q   <= '0;
      end else begin
         mem_we_q <= wr;
         if (restart) begin
            ptr_q       <= '0;
            cnt_q       <= '0;
            wrapped_q   <= 1'b0;
            trig_addr_q <= '0;
         end else begin
            if (wr) begin
               mem_addr_q <= ptr_q;
               mem_din_q  <= SB_DW'(fm_data[TP_DW-1:0]);
               ptr_q      <= ptr_q + 1'b1;
               if (&ptr_q) wrapped_q <= 1'b1;
            end
            if (trig_hit) begin
               trig_addr_q <= ptr_q;
               cnt_q       <= post_trig - ADDR_W'(fm_vld);
            end else if (wr && state_q == StPost) begin
               cnt_q <= cnt_q - 1'b1;
            end
         end
      end
   end

   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_din   = mem_din_q;
   assign wrapped   = wrapped_q;
   assign trig_addr = trig_addr_q;

endmodule

// File: tb/tb_fm_sb_capture.sv
// Directed bench for fm_sb_capture: a vector table on the default instance
// plus a wrap sequence on a small ADDR_W=3 instance.
module tb_fm_sb_capture;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [255:0] fm_data = '0;
   logic         fm_vld = 1'b0;
   logic [1:0]   pb_mode = 2'd0;
   logic         arm = 1'b0;
   logic         trig = 1'b0;
   logic [9:0]   post_trig = '0;
   logic [2:0]   post_trig3;

   logic         mem_we, frozen, wrapped;
   logic [9:0]   mem_addr, trig_addr;
   logic [63:0]  mem_din;
   logic [1:0]   state_o;

   logic         mem_we3, frozen3, wrapped3;
   logic [2:0]   mem_addr3, trig_addr3;
   logic [63:0]  mem_din3;
   logic [1:0]   state3;

   int pass_cnt = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;
   assign post_trig3 = post_trig[2:0];

   fm_sb_capture #(.TP_DW(51), .SB_DW(64), .MON_DW(256), .ADDR_W(10)) dut (
      .clk(clk), .rst(rst), .fm_data(fm_data), .fm_vld(fm_vld), .pb_mode(pb_mode),
      .arm(arm), .trig(trig), .post_trig(post_trig), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_din(mem_din), .frozen(frozen), .wrapped(wrapped),
      .trig_addr(trig_addr), .state_o(state_o)
   );

   fm_sb_capture #(.TP_DW(51), .SB_DW(64), .MON_DW(256), .ADDR_W(3)) dut3 (
      .clk(clk), .rst(rst), .fm_data(fm_data), .fm_vld(fm_vld), .pb_mode(pb_mode),
      .arm(arm), .trig(trig), .post_trig(post_trig3), .mem_we(mem_we3),
      .mem_addr(mem_addr3), .mem_din(mem_din3), .frozen(frozen3), .wrapped(wrapped3),
      .trig_addr(trig_addr3), .state_o(state3)
   );

   typedef struct {
      logic        rst, arm, trig, vld;
      logic [1:0]  pb;
      logic [9:0]  pt;
      int          dk;
      logic        we;
      logic [9:0]  addr;
      logic        frz, wrp;
      logic [9:0]  ta;
      logic [1:0]  st;
   } vec_t;

   vec_t vq[$];

   function automatic logic [50:0] dv(input int k);
      return 51'h4_DEAD_BEEF_0000 + 51'(k * 4097);
   endfunction

   function automatic vec_t mk(input logic r, a, t, v, input logic [1:0] pb,
                               input logic [9:0] pt, input int dk, input logic we,
                               input logic [9:0] addr, input logic frz, wrp,
                               input logic [9:0] ta, input logic [1:0] st);
      vec_t x;
      x.rst = r; x.arm = a; x.trig = t; x.vld = v; x.pb = pb; x.pt = pt; x.dk = dk;
      x.we = we; x.addr = addr; x.frz = frz; x.wrp = wrp; x.ta = ta; x.st = st;
      return x;
   endfunction

   // Upper tap bits are all ones so missing zero-padding shows up in mem_din.
   task automatic step(input logic r, a, t, v, input logic [1:0] pb, input logic [9:0] pt,
                       input int dk);
      rst = r; arm = a; trig = t; fm_vld = v; pb_mode = pb; post_trig = pt;
      fm_data = {{205{1'b1}}, dv(dk)};
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   initial begin
      // rst arm trig vld pb pt dk | we addr frz wrp ta st
      vq.push_back(mk(1,0,0,0,0,0,0,  0,0,0,0,0,0));  // 0 reset
      vq.push_back(mk(0,1,0,0,0,0,0,  0,0,0,0,0,1));  // 1 arm
      for (int k = 0; k < 5; k++)
         vq.push_back(mk(0,0,0,1,0,0,k, 1,10'(k),0,0,0,1));  // 2..6
      vq.push_back(mk(0,0,0,0,0,0,0,  0,4,0,0,0,1));  // 7 idle, addr holds
      vq.push_back(mk(0,1,0,0,0,0,0,  0,4,0,0,0,1));  // 8 re-arm in capture
      for (int k = 0; k < 4; k++)
         vq.push_back(mk(0,0,0,1,0,0,k, 1,10'(k),0,0,0,1));  // 9..12
      vq.push_back(mk(0,0,1,1,0,3,4,  1,4,0,0,4,2));  // 13 trig, post_trig=3
      vq.push_back(mk(0,0,0,1,0,0,5,  1,5,0,0,4,2));  // 14
      vq.push_back(mk(0,0,0,1,0,0,6,  1,6,1,0,4,3));  // 15 last post write
      vq.push_back(mk(0,0,0,1,0,0,7,  0,6,1,0,4,3));  // 16 frozen, no write
      vq.push_back(mk(0,0,1,1,0,2,8,  0,6,1,0,4,3));  // 17 trig in frozen
      vq.push_back(mk(0,1,1,0,0,2,0,  0,6,0,0,0,1));  // 18 arm+trig: arm wins
      vq.push_back(mk(0,0,0,1,0,0,1,  1,0,0,0,0,1));  // 19
      vq.push_back(mk(0,0,1,1,0,0,2,  1,1,1,0,1,3));  // 20 post_trig=0
      vq.push_back(mk(0,0,0,1,0,0,3,  0,1,1,0,1,3));  // 21
      vq.push_back(mk(0,1,0,0,0,0,0,  0,1,0,0,0,1));  // 22 re-arm clears
      vq.push_back(mk(0,0,0,1,0,0,4,  1,0,0,0,0,1));  // 23 pointer back at 0
      vq.push_back(mk(0,0,0,1,0,0,5,  1,1,0,0,0,1));  // 24
      vq.push_back(mk(0,0,1,1,0,5,6,  1,2,0,0,2,2));  // 25 into POST
      vq.push_back(mk(0,0,0,1,1,0,7,  0,2,0,0,2,0));  // 26 playback
      vq.push_back(mk(0,1,0,0,1,0,0,  0,2,0,0,2,0));  // 27 arm ignored
      vq.push_back(mk(0,1,0,0,0,0,0,  0,2,0,0,0,1));  // 28 arm in spy mode
      vq.push_back(mk(0,0,0,1,0,0,0,  1,0,0,0,0,1));  // 29
      vq.push_back(mk(0,0,1,1,0,4,1,  1,1,0,0,1,2));  // 30 into POST
      vq.push_back(mk(0,0,0,1,0,0,2,  1,2,0,0,1,2));  // 31
      vq.push_back(mk(1,0,0,1,0,0,3,  0,0,0,0,0,0));  // 32 reset mid-POST
      vq.push_back(mk(0,1,1,0,0,3,0,  0,0,0,0,0,1));  // 33 arm+trig in IDLE
      vq.push_back(mk(0,0,0,1,0,0,4,  1,0,0,0,0,1));  // 34
      vq.push_back(mk(0,0,0,1,2,0,5,  0,0,0,0,0,0));  // 35 pb_mode=2

      repeat (2) @(posedge clk);
      #1;

      foreach (vq[i]) begin
         step(vq[i].rst, vq[i].arm, vq[i].trig, vq[i].vld, vq[i].pb, vq[i].pt, vq[i].dk);
         total_cnt++;
         if (mem_we === vq[i].we && mem_addr === vq[i].addr && frozen === vq[i].frz &&
             wrapped === vq[i].wrp && trig_addr === vq[i].ta && state_o === vq[i].st &&
             (!vq[i].we || mem_din === {13'd0, dv(vq[i].dk)}))
            pass_cnt++;
         else
            $display("FAIL row%0d: got we=%0b addr=%0d din=%h frz=%0b wrp=%0b ta=%0d st=%0d, expected we=%0b addr=%0d din=%h frz=%0b wrp=%0b ta=%0d st=%0d",
                     i, mem_we, mem_addr, mem_din, frozen, wrapped, trig_addr, state_o,
                     vq[i].we, vq[i].addr, {13'd0, dv(vq[i].dk)}, vq[i].frz, vq[i].wrp,
                     vq[i].ta, vq[i].st);
      end

      // Wrap on the 8-deep instance.
      step(1, 0, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0, 0);
      chk("wrap_arm_state", 64'(state3), 64'd1);
      for (int i = 0; i < 10; i++) begin
         step(0, 0, 0, 1, 0, 0, 20 + i);
         chk("wrap_we", 64'(mem_we3), 64'd1);
         chk("wrap_addr", 64'(mem_addr3), 64'(i % 8));
         chk("wrap_din", mem_din3, {13'd0, dv(20 + i)});
         if (i < 7) chk("wrap_flag_low", 64'(wrapped3), 64'd0);
         if (i > 7) chk("wrap_flag_high", 64'(wrapped3), 64'd1);
      end
      step(0, 0, 1, 0, 0, 0, 0);
      chk("wrap_trig_addr", 64'(trig_addr3), 64'd2);
      chk("wrap_frozen_state", 64'(state3), 64'd3);
      chk("wrap_frozen", 64'(frozen3), 64'd1);
      chk("wrap_kept", 64'(wrapped3), 64'd1);
      step(0, 1, 0, 0, 0, 0, 0);
      chk("rearm_wrapped", 64'(wrapped3), 64'd0);
      chk("rearm_frozen", 64'(frozen3), 64'd0);
      chk("rearm_trig_addr", 64'(trig_addr3), 64'd0);
      step(0, 0, 0, 1, 0, 0, 40);
      chk("rearm_addr", 64'(mem_addr3), 64'd0);
      chk("rearm_we", 64'(mem_we3), 64'd1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
